// File: rtl/maf_pkg.sv
// maf_pkg: shared sizing helpers for the moving-average filter.
//   win_len(log2_n)       -> window length N = 2^log2_n
//   sum_width(dw, log2_n) -> width that holds N*(2^dw-1) without overflow
package maf_pkg;

  function automatic int win_len(input int log2_n);
    return 1 << log2_n;
  endfunction

  function automatic int sum_width(input int dw, input int log2_n);
    return dw + log2_n;
  endfunction

endpackage

// File: rtl/maf_history.sv
// maf_history: N-entry circular sample history for the moving average.
// The write pointer always addresses the oldest entry, so the value to be
// subtracted is read from the slot that the incoming sample overwrites.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_clear      : synchronous clear of pointer and every entry
//   i_we         : store i_din at the pointer and advance it
//   i_din        : sample to store
//   o_oldest     : entry under the pointer (0 when the window is not yet full)
module maf_history
  import maf_pkg::*;
#(
  parameter int DW     = 5,
  parameter int LOG2_N = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_we,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_oldest
);

  localparam int N = win_len(LOG2_N);

  logic [LOG2_N-1:0]        r_ptr;
  logic [N-1:0][DW-1:0]     w_entries;

  // Pointer is exactly LOG2_N bits wide, so N-1 wraps to 0 naturally.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_ptr <= '0;
    end else if (i_we) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  // Entries are plain registers (not RAM) because clear must zero all of
  // them in a single cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_entry
      logic [DW-1:0] r_q;
      always_ff @(posedge clk) begin
        if (reset || i_clear) begin
          r_q <= '0;
        end else if (i_we && (r_ptr == LOG2_N'(gi))) begin
          r_q <= i_din;
        end
      end
      assign w_entries[gi] = r_q;
    end
  endgenerate

  assign o_oldest = w_entries[r_ptr];

endmodule

// File: rtl/maf_window_param.sv
// maf_window_param: running sum and mean over the last N = 2^LOG2_N samples.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (highest priority)
//   in_valid/din : sample accepted on every edge with in_valid=1, flush=0
//   flush        : synchronous window clear; wins over in_valid
//   sum          : sum of the last min(k,N) accepted samples
//   mean         : sum / N (truncated, or round-half-up when ROUND=1)
//   out_valid    : one-cycle pulse the cycle after each acceptance
//   window_full  : N or more samples accepted since the last reset/flush
// All outputs come from registers; mean is a pure function of the sum register.
module maf_window_param
  import maf_pkg::*;
#(
  parameter int DW     = 5,
  parameter int LOG2_N = 3,
  parameter int ROUND  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DW-1:0]        din,
  input  logic                 flush,
  output logic [DW+LOG2_N-1:0] sum,
  output logic [DW-1:0]        mean,
  output logic                 out_valid,
  output logic                 window_full
);

  localparam int N  = win_len(LOG2_N);
  localparam int SW = sum_width(DW, LOG2_N);
  localparam int CW = LOG2_N + 1;

  logic          w_accept;
  logic [DW-1:0] w_oldest;
  logic [SW-1:0] w_sum_next;
  logic [SW-1:0] r_sum;
  logic [CW-1:0] r_fill;
  logic          r_out_valid;

  // Reset is handled by priority inside each register stage.
  assign w_accept = in_valid & ~flush;

  maf_history #(
    .DW     (DW),
    .LOG2_N (LOG2_N)
  ) u_history (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (flush),
    .i_we     (w_accept),
    .i_din    (din),
    .o_oldest (w_oldest)
  );

  // The intermediate sum+din can exceed the window total, but the result
  // after subtracting the oldest sample always fits in SW bits, so modular
  // arithmetic at SW bits is exact.
  assign w_sum_next = r_sum + SW'(din) - SW'(w_oldest);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum       <= '0;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_sum       <= '0;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum <= w_sum_next;
        if (r_fill != CW'(N)) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

  generate
    if (ROUND != 0) begin : g_round
      // One extra bit keeps the half-LSB bias from overflowing a full sum.
      logic [SW:0] w_biased;
      assign w_biased = {1'b0, r_sum} + (SW+1)'(N / 2);
      assign mean     = DW'(w_biased >> LOG2_N);
    end else begin : g_trunc
      assign mean = DW'(r_sum >> LOG2_N);
    end
  endgenerate

  assign sum         = r_sum;
  assign out_valid   = r_out_valid;
  assign window_full = (r_fill == CW'(N));

endmodule

// File: tb/tb_maf_window_param.sv
// Scoreboard bench: the driver computes, from a plain list of recently
// accepted samples, the state each edge should produce and queues it; a
// monitor 1 time unit after every rising edge pops and compares. Two DUTs
// share the stimulus, one truncating and one rounding.
module tb_maf_window_param;

  localparam int DW     = 5;
  localparam int LOG2_N = 3;
  localparam int N      = 8;
  localparam int SW     = DW + LOG2_N;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          flush;
  logic [DW-1:0] din;

  logic [SW-1:0] sum_t,   sum_r;
  logic [DW-1:0] mean_t,  mean_r;
  logic          ov_t,    ov_r;
  logic          full_t,  full_r;

  always #5 clk = ~clk;

  maf_window_param #(.DW(DW), .LOG2_N(LOG2_N), .ROUND(0)) dut_trunc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din(din), .flush(flush),
    .sum(sum_t), .mean(mean_t), .out_valid(ov_t), .window_full(full_t)
  );

  maf_window_param #(.DW(DW), .LOG2_N(LOG2_N), .ROUND(1)) dut_round (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din(din), .flush(flush),
    .sum(sum_r), .mean(mean_r), .out_valid(ov_r), .window_full(full_r)
  );

  typedef struct packed {
    logic          ov;
    logic [SW-1:0] sum;
    logic [DW-1:0] m_trunc;
    logic [DW-1:0] m_round;
    logic          full;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];
  int   acc_cnt = 0;
  int   n_vec   = 0;
  int   n_bad   = 0;
  int   n_txn   = 0;
  exp_t mon_e;

  // Reference model: window = last N accepted samples since the last clear.
  task automatic step(input bit r, input bit f, input bit v, input int d);
    exp_t e;
    int   s;
    @(negedge clk);
    reset    = r;
    flush    = f;
    in_valid = v;
    din      = d[DW-1:0];
    if (r || f) begin
      hist.delete();
      acc_cnt = 0;
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() > N) void'(hist.pop_front());
      acc_cnt++;
    end
    s = 0;
    foreach (hist[i]) s += hist[i];
    e.ov      = !r && !f && v;
    e.sum     = SW'(s);
    e.m_trunc = DW'(s / N);
    e.m_round = DW'((s + N / 2) / N);
    e.full    = (acc_cnt >= N);
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if ({ov_t, sum_t, mean_t, full_t} !== {mon_e.ov, mon_e.sum, mon_e.m_trunc, mon_e.full}) begin
        n_bad++;
        $display("FAIL trunc vec %0d: got ov=%0b sum=%0d mean=%0d full=%0b, want ov=%0b sum=%0d mean=%0d full=%0b",
                 n_vec, ov_t, sum_t, mean_t, full_t, mon_e.ov, mon_e.sum, mon_e.m_trunc, mon_e.full);
      end
      n_vec++;
      if ({ov_r, sum_r, mean_r, full_r} !== {mon_e.ov, mon_e.sum, mon_e.m_round, mon_e.full}) begin
        n_bad++;
        $display("FAIL round vec %0d: got ov=%0b sum=%0d mean=%0d full=%0b, want ov=%0b sum=%0d mean=%0d full=%0b",
                 n_vec, ov_r, sum_r, mean_r, full_r, mon_e.ov, mon_e.sum, mon_e.m_round, mon_e.full);
      end
      if (mon_e.ov) begin
        n_txn++;
        $display("txn %0d: sum=%0d mean_trunc=%0d mean_round=%0d full=%0b",
                 n_txn, mon_e.sum, mon_e.m_trunc, mon_e.m_round, mon_e.full);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    din      = '0;

    repeat (3) step(1, 0, 0, 0);

    // Ramp 1..10: full on the 8th sample, then slides.
    for (int i = 1; i <= 10; i++) step(0, 0, 1, i);
    step(1, 0, 0, 0);

    // Maximum value: sum saturates at 248, both means 31.
    repeat (10) step(0, 0, 1, 31);
    step(0, 1, 0, 0);

    // Rounding: single 4 followed by zeros.
    step(0, 0, 1, 4);
    repeat (7) step(0, 0, 1, 0);
    step(0, 1, 0, 0);

    // Gapped input with junk on din while idle.
    step(0, 0, 1, 7);
    step(0, 0, 0, 13);
    step(0, 0, 0, 22);
    step(0, 0, 1, 9);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);

    // Flush collides with a valid sample; the sample is discarded.
    repeat (5) step(0, 0, 1, 3);
    step(0, 1, 1, 20);
    step(0, 0, 1, 2);
    step(0, 0, 0, 0);

    // Mid-stream reset with in_valid held high.
    for (int i = 0; i < 12; i++) step(0, 0, 1, $urandom_range(0, 31));
    step(1, 0, 1, 17);
    step(0, 0, 1, 5);
    step(0, 0, 1, 5);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      d = ($urandom % 4 == 0) ? 31 : $urandom_range(0, 31);
      step(($urandom % 150) == 0, ($urandom % 40) == 0, ($urandom % 4) != 0, d);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
